// File: rtl/fp_serial_alu_seq.sv
// Byte-serial sequencer in front of the FP ALU core: loads A/B in BUS_W beats, runs one core op, streams R back.
// Optional macro STATUS_BYTE_EN appends a {zeros, flags} beat after the result.
module fp_serial_alu_seq #(
    parameter int OP_W    = 32,
    parameter int BUS_W   = 8,
    parameter int OPC_W   = 2,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BUS_W-1:0]   in_data,
    input  logic               in_valid,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               start,
    output logic [BUS_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done,
    output logic               busy,
    output logic [STATE_W-1:0] state_out,
    output logic [OP_W-1:0]    core_a,
    output logic [OP_W-1:0]    core_b,
    output logic [OPC_W-1:0]   core_op,
    output logic               core_req,
    input  logic               core_ack,
    input  logic [OP_W-1:0]    core_result,
    input  logic [3:0]         core_flags
);
    localparam int BEATS = OP_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4,
        STATUS = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  a_reg, b_reg, r_reg;
    logic [OPC_W-1:0] opc_reg;
    logic             last_beat;
    logic             beat_fire;

`ifdef STATUS_BYTE_EN
    logic [3:0] flags_reg;
`else
    logic unused_flags;
    assign unused_flags = ^core_flags;
`endif

    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign busy      = (state != IDLE);
    assign state_out = STATE_W'(state);
    assign core_a    = a_reg;
    assign core_b    = b_reg;
    assign core_op   = opc_reg;

    // Valid/ready: a beat moves on any cycle where the sender's valid and the receiver's ready are both high;
    // the sender holds its data unchanged until then. Operand input has no ready (in_valid alone moves a beat).
    always_comb begin
        state_next = state;
        beat_fire  = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        done       = 1'b0;
        core_req   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD_A;
            end
            LOAD_A: begin
                beat_fire = in_valid;
                if (in_valid && last_beat) state_next = LOAD_B;
            end
            LOAD_B: begin
                beat_fire = in_valid;
                if (in_valid && last_beat) state_next = EXEC;
            end
            EXEC: begin
                core_req = 1'b1;
                if (core_ack) state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = r_reg[int'(cnt)*BUS_W +: BUS_W];
                beat_fire = out_ready;
                if (out_ready && last_beat) begin
`ifdef STATUS_BYTE_EN
                    state_next = STATUS;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef STATUS_BYTE_EN
            STATUS: begin
                out_valid = 1'b1;
                out_data  = BUS_W'(flags_reg);
                if (out_ready) state_next = DONE;
            end
`endif
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            r_reg   <= '0;
            opc_reg <= '0;
`ifdef STATUS_BYTE_EN
            flags_reg <= '0;
`endif
        end else begin
            state <= state_next;
            // Beat index restarts on every state change so each phase counts from its own LSB beat.
            if (state_next != state) cnt <= '0;
            else if (beat_fire)      cnt <= cnt + CNT_W'(1);
            if (state == IDLE && start)       opc_reg <= opcode;
            if (state == LOAD_A && in_valid)  a_reg[int'(cnt)*BUS_W +: BUS_W] <= in_data;
            if (state == LOAD_B && in_valid)  b_reg[int'(cnt)*BUS_W +: BUS_W] <= in_data;
            if (state == EXEC && core_ack) begin
                r_reg <= core_result;
`ifdef STATUS_BYTE_EN
                flags_reg <= core_flags;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fp_serial_alu_seq.sv
// Directed bench for fp_serial_alu_seq: 32/8 instance for protocol scenarios, 16/16 instance for single-beat latency.
`timescale 1ns/1ps
module tb_fp_serial_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [1:0]  opcode;
    logic        start;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        busy;
    logic [3:0]  state_out;
    logic [31:0] core_a, core_b;
    logic [1:0]  core_op;
    logic        core_req;
    logic        core_ack;
    logic [31:0] core_result;
    logic [3:0]  core_flags;

    logic [15:0] in_data16, out_data16, core_a16, core_b16;
    logic        in_valid16, start16, out_valid16, out_ready16, done16, busy16, core_req16, core_ack16;
    logic [1:0]  opcode16, core_op16;
    logic [3:0]  state_out16;
    logic [15:0] core_result16 = 16'h3C00;
    logic [3:0]  core_flags16 = 4'h0;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;
    int ack_delay = 0;
    int req_cnt = 0;
    int req_rises = 0;
    logic [31:0] cap_a, cap_b;
    logic [1:0]  cap_op;
    logic [3:0]  trace_q[$];
    logic [3:0]  exp_tr[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int done_cnt, stable_err, start_cyc, done_cyc;
    bit timed_out;

    always #5 clk = ~clk;

    fp_serial_alu_seq #(.OP_W(32), .BUS_W(8), .OPC_W(2), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .opcode(opcode), .start(start),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done), .busy(busy),
        .state_out(state_out), .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_req(core_req),
        .core_ack(core_ack), .core_result(core_result), .core_flags(core_flags)
    );

    fp_serial_alu_seq #(.OP_W(16), .BUS_W(16), .OPC_W(2), .STATE_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_data(in_data16), .in_valid(in_valid16), .opcode(opcode16), .start(start16),
        .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready16), .done(done16), .busy(busy16),
        .state_out(state_out16), .core_a(core_a16), .core_b(core_b16), .core_op(core_op16), .core_req(core_req16),
        .core_ack(core_ack16), .core_result(core_result16), .core_flags(core_flags16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // Core model: acks ack_delay cycles after the first EXEC cycle; also logs state changes.
    initial begin
        core_ack   = 1'b0;
        core_ack16 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (core_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    req_rises++;
                    cap_a  = core_a;
                    cap_b  = core_b;
                    cap_op = core_op;
                end
            end else begin
                req_cnt = 0;
            end
            core_ack   = core_req && (req_cnt == ack_delay + 1);
            core_ack16 = core_req16;
            if (trace_q.size() == 0 || trace_q[$] != state_out) trace_q.push_back(state_out);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2ms", $time);
        $fatal(1);
    end

    task automatic load_beats(input logic [31:0] v, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                tick();
            end
            in_valid = 1'b1;
            in_data  = v[k*8 +: 8];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Drives out_ready (optionally stalling 2 cycles at beat stall_at), gathers accepted beats and done pulses.
    task automatic collect(input int stall_at);
        int stall_left = 0;
        bit stalled = 0;
        bit holding = 0;
        logic [7:0] held = '0;
        int after = -1;
        got_q.delete();
        done_cnt   = 0;
        stable_err = 0;
        timed_out  = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (out_valid && !stalled && got_q.size() == stall_at) begin
                stall_left = 2;
                stalled    = 1;
            end
            out_ready = (stall_left == 0);
            if (out_valid && !out_ready) begin
                if (holding && out_data !== held) stable_err++;
                held    = out_data;
                holding = 1;
            end else begin
                holding = 0;
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) begin
                done_cnt++;
                start = 1'b0;
                if (after < 0) begin
                    after    = 3;
                    done_cyc = cyc_no;
                end
            end
            if (stall_left > 0) stall_left--;
            if (after == 0) begin
                timed_out = 0;
                break;
            end
            if (after > 0) after--;
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic run_op(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b, input bit gaps,
                          input bit hold, input int stall_at, input int ack_dly, input logic [31:0] res,
                          input logic [3:0] flg);
        ack_delay   = ack_dly;
        core_result = res;
        core_flags  = flg;
        req_rises   = 0;
        trace_q.delete();
        trace_q.push_back(state_out);
        opcode    = opc;
        start     = 1'b1;
        start_cyc = cyc_no;
        tick();
        if (!hold) start = 1'b0;
        else       opcode = ~opc;
        load_beats(a, gaps);
        load_beats(b, gaps);
        collect(stall_at);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({state_out, busy, done, out_valid, out_data, core_req, core_op, core_a, core_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got state=%0d busy=%b done=%b ov=%b od=%h req=%b op=%0d a=%h b=%h required all 0",
                     state_out, busy, done, out_valid, out_data, core_req, core_op, core_a, core_b);
        end
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (state_out !== 4'd0 || busy !== 1'b0 || core_a !== 32'h0) begin
            errors++;
            $display("FAIL idle_ignores_in_valid: got state=%0d busy=%b a=%h required 0 0 00000000", state_out, busy, core_a);
        end
    endtask

    task automatic check_beats(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_beat_count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (timed_out || done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done: got %0d pulses (timeout=%0d) required 1", name, done_cnt, timed_out);
        end
    endtask

    task automatic test_add();
        run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, -1, 3, 32'h4040_0000, 4'h0);
        exp_q = {8'h00, 8'h00, 8'h40, 8'h40};
`ifdef STATUS_BYTE_EN
        exp_q.push_back(8'h00);
        exp_tr = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
`else
        exp_tr = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd0};
`endif
        check_beats("add");
        checks++;
        if (cap_a !== 32'h3F80_0000 || cap_b !== 32'h4000_0000 || cap_op !== 2'd0) begin
            errors++;
            $display("FAIL add_operands: got a=%h b=%h op=%0d required 3f800000 40000000 0", cap_a, cap_b, cap_op);
        end
        checks++;
        if (trace_q != exp_tr) begin
            errors++;
            $display("FAIL add_state_walk: got %p required %p", trace_q, exp_tr);
        end
    endtask

    task automatic test_backpressure();
        run_op(2'd1, 32'h1234_5678, 32'hA5C3_0F96, 1'b1, 1'b0, 2, 1, 32'hDEAD_BEEF, 4'h0);
        exp_q = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef STATUS_BYTE_EN
        exp_q.push_back(8'h00);
`endif
        check_beats("bp");
        checks++;
        if (cap_a !== 32'h1234_5678 || cap_b !== 32'hA5C3_0F96 || cap_op !== 2'd1) begin
            errors++;
            $display("FAIL bp_operands: got a=%h b=%h op=%0d required 12345678 a5c30f96 1", cap_a, cap_b, cap_op);
        end
        checks++;
        if (stable_err != 0) begin
            errors++;
            $display("FAIL bp_hold_stable: got %0d changes while stalled required 0", stable_err);
        end
    endtask

    task automatic test_reset_mid_op();
        int dn = 0;
        opcode = 2'd2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        load_beats(32'h1111_1111, 1'b0);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h22;
            tick();
        end
        rst     = 1'b1;
        in_data = 8'h22;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({state_out, busy, done, out_valid, out_data, core_req, core_op, core_a, core_b} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got state=%0d busy=%b req=%b op=%0d a=%h b=%h required all 0",
                     state_out, busy, core_req, core_op, core_a, core_b);
        end
        for (int k = 0; k < 5; k++) begin
            if (done) dn++;
            tick();
        end
        checks++;
        if (dn != 0 || state_out !== 4'd0) begin
            errors++;
            $display("FAIL midreset_no_done: got done=%0d state=%0d required 0 0", dn, state_out);
        end
        run_op(2'd3, 32'hC000_0000, 32'h4080_0000, 1'b0, 1'b0, -1, 0, 32'hC100_0000, 4'h0);
        exp_q = {8'h00, 8'h00, 8'h00, 8'hC1};
`ifdef STATUS_BYTE_EN
        exp_q.push_back(8'h00);
`endif
        check_beats("fresh");
    endtask

    task automatic test_start_hold();
        run_op(2'd2, 32'hC000_0000, 32'h3F80_0000, 1'b0, 1'b1, -1, 2, 32'h0102_0304, 4'h0);
        exp_q = {8'h04, 8'h03, 8'h02, 8'h01};
`ifdef STATUS_BYTE_EN
        exp_q.push_back(8'h00);
`endif
        check_beats("hold");
        checks++;
        if (cap_op !== 2'd2 || core_op !== 2'd2 || req_rises != 1) begin
            errors++;
            $display("FAIL hold_no_restart: got cap_op=%0d core_op=%0d req_rises=%0d required 2 2 1",
                     cap_op, core_op, req_rises);
        end
        tick();
        tick();
        checks++;
        if (state_out !== 4'd0) begin
            errors++;
            $display("FAIL hold_idle_after: got state=%0d required 0", state_out);
        end
    endtask

    task automatic test_flags();
        int lat;
        run_op(2'd1, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 1'b0, -1, 0, 32'h7FC0_0000, 4'b0101);
        exp_q = {8'h00, 8'h00, 8'hC0, 8'h7F};
`ifdef STATUS_BYTE_EN
        exp_q.push_back(8'h05);
        lat = 16;
`else
        lat = 15;
`endif
        check_beats("flags");
        checks++;
        if (done_cyc - start_cyc + 1 != lat) begin
            errors++;
            $display("FAIL latency32: got %0d cycles required %0d", done_cyc - start_cyc + 1, lat);
        end
    endtask

    task automatic test_width16();
        int s;
        int nb = 0;
        int lat;
        int exp_nb;
        logic [15:0] first = '0;
        bit seen = 0;
`ifdef STATUS_BYTE_EN
        lat    = 7;
        exp_nb = 2;
`else
        lat    = 6;
        exp_nb = 1;
`endif
        opcode16 = 2'd0;
        start16  = 1'b1;
        s = cyc_no;
        tick();
        start16    = 1'b0;
        in_valid16 = 1'b1;
        in_data16  = 16'h3800;
        tick();
        in_data16 = 16'h3800;
        tick();
        in_valid16 = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (out_valid16 && out_ready16) begin
                if (nb == 0) first = out_data16;
                nb++;
            end
            if (done16) seen = 1;
            else        tick();
        end
        checks++;
        if (first !== 16'h3C00 || nb != exp_nb) begin
            errors++;
            $display("FAIL w16_result: got %h in %0d beats required 3c00 in %0d", first, nb, exp_nb);
        end
        checks++;
        if (!seen || cyc_no - s + 1 != lat) begin
            errors++;
            $display("FAIL w16_latency: got %0d cycles (done seen=%0d) required %0d", cyc_no - s + 1, seen, lat);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        opcode      = '0;
        start       = 1'b0;
        out_ready   = 1'b1;
        core_result = '0;
        core_flags  = '0;
        in_data16   = '0;
        in_valid16  = 1'b0;
        opcode16    = '0;
        start16     = 1'b0;
        out_ready16 = 1'b1;
        test_reset();
        test_add();
        test_backpressure();
        test_reset_mid_op();
        test_start_hold();
        test_flags();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
